// File: rtl/store_narrow_rmw.sv
// Narrows a register value to byte/half/word and stores it to a word-only memory,
// using read-modify-write for sub-word stores. Optional: `define ALIGN_CHECK_EN.
module store_narrow_rmw #(
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              StReq,
  input  logic [ADDR_W-1:0] StAddr,
  input  logic [31:0]       StData,
  input  logic [1:0]        StSize,
  output logic              StBusy,
  output logic              StDone,
  output logic              StErr,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemRd,
  output logic              MemWr,
  output logic [31:0]       MemWData,
  input  logic [31:0]       MemRData,
  input  logic              MemAck
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic [31:0]       r_wdata;
  logic [31:0]       w_merged;
  logic              w_narrow;
  logic              w_misaligned;

  // Sizes 00/01 need the old word; 10/11 are full-word writes.
  assign w_narrow = ~StSize[1];

`ifdef ALIGN_CHECK_EN
  logic r_err;

  assign w_misaligned = ((StSize == 2'b01) && StAddr[0]) ||
                        (StSize[1] && (StAddr[1:0] != 2'b00));
`else
  assign w_misaligned = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: default assignment first so no path leaves w_next unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (StReq) begin
          if (w_misaligned)  w_next = S_DONE;
          else if (w_narrow) w_next = S_READ;
          else               w_next = S_WRITE;
        end
      end
      S_READ:  if (MemAck) w_next = S_WRITE;
      S_WRITE: if (MemAck) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Lane merge: StData's low byte/half is still in r_wdata[15:0] until the read returns.
  always_comb begin
    w_merged = MemRData;
    if (r_size == 2'b01) begin
      w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
    end else begin
      w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    end
  end

  // NOTE: the operand latches are reset too, so MemAddr/MemWData read 0 after reset.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_addr  <= '0;
      r_size  <= '0;
      r_wdata <= '0;
`ifdef ALIGN_CHECK_EN
      r_err   <= 1'b0;
`endif
    end else begin
      if ((r_state == S_IDLE) && StReq) begin
        r_addr  <= StAddr;
        r_size  <= StSize;
        r_wdata <= StData;
`ifdef ALIGN_CHECK_EN
        r_err   <= w_misaligned;
`endif
      end else if ((r_state == S_READ) && MemAck) begin
        r_wdata <= w_merged;
      end
    end
  end

  always_comb begin
    StBusy   = (r_state != S_IDLE);
    MemRd    = (r_state == S_READ);
    MemWr    = (r_state == S_WRITE);
    StDone   = (r_state == S_DONE);
`ifdef ALIGN_CHECK_EN
    StErr    = (r_state == S_DONE) && r_err;
`else
    StErr    = 1'b0;
`endif
    MemAddr  = {r_addr[ADDR_W-1:2], 2'b00};
    MemWData = r_wdata;
  end

endmodule

// File: tb/tb_store_narrow_rmw.sv
// Randomized self-checking bench for store_narrow_rmw with a word-memory model
// that acknowledges after a programmable number of wait cycles.
module tb_store_narrow_rmw;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        StReq;
  logic [31:0] StAddr;
  logic [31:0] StData;
  logic [1:0]  StSize;
  logic        StBusy, StDone, StErr;
  logic [31:0] MemAddr;
  logic        MemRd, MemWr;
  logic [31:0] MemWData;
  logic [31:0] MemRData;
  logic        MemAck;

  store_narrow_rmw #(.ADDR_W(32)) u_dut (
    .CLK(CLK), .Reset(Reset), .StReq(StReq), .StAddr(StAddr), .StData(StData),
    .StSize(StSize), .StBusy(StBusy), .StDone(StDone), .StErr(StErr),
    .MemAddr(MemAddr), .MemRd(MemRd), .MemWr(MemWr), .MemWData(MemWData),
    .MemRData(MemRData), .MemAck(MemAck)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [logic [31:0]];
  int          ack_delay = 0;
  int          wait_cnt  = 0;
  logic        resp_ack  = 1'b0;
  logic        stray_ack = 1'b0;
  int          n_reads   = 0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic        both_seen = 1'b0;

  assign MemAck = resp_ack | stray_ack;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory model: ack after ack_delay wait cycles, drive read data in the ack cycle.
  initial begin
    MemRData = '0;
    forever begin
      @(negedge CLK);
      resp_ack = 1'b0;
      if (MemRd && MemWr) both_seen = 1'b1;
      if (Reset) begin
        wait_cnt = 0;
      end else if (MemRd || MemWr) begin
        if (wait_cnt >= ack_delay) begin
          resp_ack = 1'b1;
          wait_cnt = 0;
          if (MemRd) begin
            if (!mem.exists(MemAddr)) mem[MemAddr] = $urandom;
            MemRData = mem[MemAddr];
            n_reads++;
          end else begin
            mem[MemAddr] = MemWData;
            wr_addr_q.push_back(MemAddr);
            wr_data_q.push_back(MemWData);
          end
        end else begin
          wait_cnt++;
          MemRData = $urandom;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // One complete store, checked against the lane rules applied to the model memory.
  task automatic do_store(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] size, input int delay, input bit inject);
    logic [31:0] wa;
    logic [31:0] old_w;
    logic [31:0] exp_w;
    int          sh;
    int          exp_lat;
    int          cyc;
    bit          mis, narrow, bad_hold, err_seen, busy1, injected;
    wa = {addr[31:2], 2'b00};
    if (!mem.exists(wa)) mem[wa] = $urandom;
    old_w = mem[wa];
    mis = 1'b0;
`ifdef ALIGN_CHECK_EN
    mis = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
`endif
    narrow = (size == 2'b00) || (size == 2'b01);
    if (size == 2'b00) begin
      sh    = 8 * int'(addr[1:0]);
      exp_w = (old_w & ~(32'h0000_00FF << sh)) | ({24'h0, data[7:0]} << sh);
    end else if (size == 2'b01) begin
      sh    = 16 * int'(addr[1]);
      exp_w = (old_w & ~(32'h0000_FFFF << sh)) | ({16'h0, data[15:0]} << sh);
    end else begin
      exp_w = data;
    end
    exp_lat = mis ? 1 : (narrow ? 2 * delay + 3 : delay + 2);

    ack_delay = delay;
    n_reads   = 0;
    wr_addr_q.delete();
    wr_data_q.delete();
    bad_hold = 1'b0;
    err_seen = 1'b0;
    busy1    = 1'b0;
    injected = 1'b0;

    @(negedge CLK);
    StReq = 1'b1; StAddr = addr; StData = data; StSize = size;
    @(posedge CLK);
    #1;
    StReq = 1'b0; StAddr = $urandom; StData = $urandom; StSize = 2'($urandom);

    cyc = 0;
    while (cyc < 100) begin
      @(negedge CLK);
      cyc++;
      StReq = 1'b0;
      if (cyc == 1) busy1 = StBusy;
      if ((MemRd || MemWr) && (MemAddr != wa)) bad_hold = 1'b1;
      if (MemWr && (MemWData != exp_w)) bad_hold = 1'b1;
      if (inject && MemRd && !injected) begin
        injected = 1'b1;
        StReq = 1'b1; StAddr = addr ^ 32'h0000_0040; StSize = 2'b10;
      end
      if (StDone) begin
        err_seen = StErr;
        break;
      end
    end
    StReq = 1'b0;

    check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_busy"}, {31'h0, busy1}, 32'h1);
    check({tag, "_err"}, {31'h0, err_seen}, {31'h0, mis});
    check({tag, "_hold"}, {31'h0, bad_hold}, 32'h0);
    check({tag, "_reads"}, 32'(n_reads), (narrow && !mis) ? 32'h1 : 32'h0);
    check({tag, "_writes"}, 32'(wr_data_q.size()), mis ? 32'h0 : 32'h1);
    if (wr_data_q.size() > 0) begin
      check({tag, "_wdata"}, wr_data_q[0], exp_w);
      check({tag, "_waddr"}, wr_addr_q[0], wa);
    end
    @(negedge CLK);
    check({tag, "_pulse"}, {30'h0, StDone, StBusy}, 32'h0);
  endtask

  initial begin
    int done_cnt;
    bit got_wr;
    logic [31:0] r_addr_v;
    Reset = 1'b1; StReq = 1'b0; StAddr = '0; StData = '0; StSize = '0;
    #1;
    check("rst_busy", {31'h0, StBusy}, 32'h0);
    check("rst_strobes", {29'h0, MemRd, MemWr, StDone}, 32'h0);
    check("rst_err", {31'h0, StErr}, 32'h0);
    check("rst_addr", MemAddr, 32'h0);
    check("rst_wdata", MemWData, 32'h0);
    repeat (2) @(negedge CLK);
    Reset = 1'b0;
    @(negedge CLK);

    do_store("word", 32'h100, 32'hDEAD_BEEF, 2'b10, 0, 1'b0);
    mem[32'h100] = 32'h1122_3344;
    do_store("byte", 32'h102, 32'h0000_00AB, 2'b00, 0, 1'b0);
    check("byte_mem", mem[32'h100], 32'h11AB_3344);
    mem[32'h204] = 32'h5566_7788;
    do_store("half_wait", 32'h206, 32'hFFFF_CAFE, 2'b01, 2, 1'b0);
    check("half_mem", mem[32'h204], 32'hCAFE_7788);
    do_store("busy_inject", 32'h311, 32'h1234_5677, 2'b00, 1, 1'b1);
    do_store("half_odd", 32'h101, 32'h0000_BEEF, 2'b01, 0, 1'b0);
    do_store("word_odd", 32'h203, 32'h0BAD_F00D, 2'b11, 1, 1'b0);

    @(negedge CLK);
    stray_ack = 1'b1;
    @(negedge CLK);
    stray_ack = 1'b0;
    check("stray_ack", {29'h0, StBusy, MemRd, MemWr}, 32'h0);
    @(negedge CLK);
    check("stray_ack2", {30'h0, StBusy, StDone}, 32'h0);

    // Reset while WRITE is waiting for its ack.
    mem[32'h300] = $urandom;
    ack_delay = 3;
    wr_data_q.delete();
    wr_addr_q.delete();
    @(negedge CLK);
    StReq = 1'b1; StAddr = 32'h301; StData = 32'h0000_005A; StSize = 2'b00;
    @(posedge CLK);
    #1;
    StReq = 1'b0;
    got_wr = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (MemWr) begin
        got_wr = 1'b1;
        break;
      end
    end
    check("rst_reach_write", {31'h0, got_wr}, 32'h1);
    #2;
    Reset = 1'b1;
    #1;
    check("midrst_strobes", {28'h0, StBusy, MemRd, MemWr, StDone}, 32'h0);
    check("midrst_addr", MemAddr, 32'h0);
    check("midrst_wdata", MemWData, 32'h0);
    repeat (2) @(negedge CLK);
    Reset = 1'b0;
    done_cnt = 0;
    repeat (6) begin
      @(negedge CLK);
      if (StDone || StBusy) done_cnt++;
    end
    check("midrst_no_done", 32'(done_cnt), 32'h0);
    check("midrst_no_write", 32'(wr_data_q.size()), 32'h0);
    do_store("post_rst", 32'h302, 32'h0000_9876, 2'b01, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      r_addr_v = 32'h400 + (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(0, 3));
      do_store("rand", r_addr_v, $urandom, 2'($urandom_range(0, 3)),
               $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    check("rd_wr_exclusive", {31'h0, both_seen}, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
